// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: VGA timing generator and block renderer for the pong core.
// Generates 640x480@60 timing (800x525 total) by default. The raster geometry
// is parameterised so reduced-size rasters can be built for fast simulation.
// Optional feature: define PONG_CENTER_NET_EN to draw a dashed centre net.
module pong_vga_renderer #(
  parameter int CELL_SHIFT    = 2,
  parameter int PADDLE_EXTENT = 3,
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ball_x,
  input  logic [7:0] ball_y,
  input  logic [7:0] left_paddle_y,
  input  logic [7:0] right_paddle_y,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       visible,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FIELD_W = H_ACTIVE >> CELL_SHIFT;
  localparam int FIELD_H = V_ACTIVE >> CELL_SHIFT;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] EXTENT       = 10'(PADDLE_EXTENT);
  localparam logic [9:0] RIGHT_COL    = 10'(FIELD_W - 1);
  localparam logic [9:0] FIELD_W_V    = 10'(FIELD_W);
  localparam logic [9:0] FIELD_H_V    = 10'(FIELD_H);

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BALL  = '{r: 2'b11, g: 2'b11, b: 2'b11};
  localparam rgb_t RGB_LEFT  = '{r: 2'b00, g: 2'b11, b: 2'b00};
  localparam rgb_t RGB_RIGHT = '{r: 2'b11, g: 2'b00, b: 2'b11};
  localparam rgb_t RGB_BG    = '{r: 2'b00, g: 2'b00, b: 2'b00};

  logic [9:0] hcount, vcount;
  logic [7:0] ball_x_q, ball_y_q, left_y_q, right_y_q;
  logic [9:0] cx, cy;
  logic       h_last, v_last, active, snap_take;
  logic       ball_hit, left_hit, right_hit, net_hit;
  rgb_t       pix_next;

  assign h_last    = (hcount == H_LAST);
  assign v_last    = (vcount == V_LAST);
  assign active    = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  assign snap_take = (hcount == 10'd0) && (vcount == V_VIS_END);
  assign cx        = hcount >> CELL_SHIFT;
  assign cy        = vcount >> CELL_SHIFT;

  // Paddle row test in 10-bit unsigned arithmetic: rows near 0 clip, never wrap.
  function automatic logic paddle_row(input logic [9:0] row, input logic [7:0] py);
    return (row + EXTENT >= {2'b00, py}) && (row <= {2'b00, py} + EXTENT);
  endfunction

  assign ball_hit  = (cx == {2'b00, ball_x_q}) && (cy == {2'b00, ball_y_q}) &&
                     ({2'b00, ball_x_q} < FIELD_W_V) && ({2'b00, ball_y_q} < FIELD_H_V);
  assign left_hit  = (cx == 10'd0) && paddle_row(cy, left_y_q);
  assign right_hit = (cx == RIGHT_COL) && paddle_row(cy, right_y_q);

`ifdef PONG_CENTER_NET_EN
  localparam logic [9:0] NET_COL = 10'(FIELD_W / 2);
  // Dashed net: four cell rows lit, four dark.
  assign net_hit = (cx == NET_COL) && !cy[2];
`else
  assign net_hit = 1'b0;
`endif

  // Raster counters: hcount wraps every line, vcount advances on each wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_last) begin
      hcount <= '0;
      vcount <= v_last ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // Per-frame snapshot of positions, taken on the first blanking line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      left_y_q  <= '0;
      right_y_q <= '0;
    end else if (snap_take) begin
      ball_x_q  <= ball_x;
      ball_y_q  <= ball_y;
      left_y_q  <= left_paddle_y;
      right_y_q <= right_paddle_y;
    end
  end

  // Colour priority: ball over paddles over net over background.
  // NOTE: pix_next gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pix_next = RGB_BG;
    if (ball_hit)       pix_next = RGB_BALL;
    else if (left_hit)  pix_next = RGB_LEFT;
    else if (right_hit) pix_next = RGB_RIGHT;
    else if (net_hit)   pix_next = '{r: 2'b01, g: 2'b01, b: 2'b01};
  end

  // Registered video outputs, all describing the same counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      visible    <= 1'b0;
      frame_tick <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      hsync      <= !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
      vsync      <= !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
      visible    <= active;
      frame_tick <= snap_take;
      red        <= active ? pix_next.r : 2'b00;
      green      <= active ? pix_next.g : 2'b00;
      blue       <= active ? pix_next.b : 2'b00;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Self-checking bench for pong_vga_renderer. A reduced raster (80x55 total,
// 64x48 active) keeps frames short; a second instance with the full 640x480
// geometry checks the real horizontal timing after reset.
module tb_pong_vga_renderer;

  localparam int CS = 2, PE = 3;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CELL = 1 << CS;
  localparam int FW = HA / CELL, FH = VA / CELL;

  localparam logic [5:0] C_WHITE = 6'b111111;
  localparam logic [5:0] C_GREEN = 6'b001100;
  localparam logic [5:0] C_MAG   = 6'b110011;
  localparam logic [5:0] C_GRAY  = 6'b010101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] ball_x = 8'd0, ball_y = 8'd0, left_paddle_y = 8'd0, right_paddle_y = 8'd0;
  logic hsync, vsync, visible, frame_tick;
  logic [1:0] red, green, blue;
  logic hsync_f, vsync_f, visible_f, frame_tick_f;
  logic [1:0] red_f, green_f, blue_f;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cnt;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } stat_t;

  always #5 clk = ~clk;

  pong_vga_renderer #(
    .CELL_SHIFT(CS), .PADDLE_EXTENT(PE),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .visible(visible), .frame_tick(frame_tick)
  );

  pong_vga_renderer dut_full (
    .clk(clk), .reset(reset),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .hsync(hsync_f), .vsync(vsync_f),
    .red(red_f), .green(green_f), .blue(blue_f),
    .visible(visible_f), .frame_tick(frame_tick_f)
  );

  // Reference model of one output sample: {hsync, vsync, visible, frame_tick, rgb}.
  function automatic logic [9:0] model_out(input int h, input int v,
                                           input logic [7:0] bx, input logic [7:0] by,
                                           input logic [7:0] lp, input logic [7:0] rp);
    logic [5:0] c;
    logic hs, vs, vis, ft;
    int col, row;
    vis = (h < HA) && (v < VA);
    hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    ft  = (h == 0) && (v == VA);
    col = h / CELL;
    row = v / CELL;
    c = 6'b000000;
    if (vis) begin
      if (int'(bx) < FW && int'(by) < FH && col == int'(bx) && row == int'(by)) c = C_WHITE;
      else if (col == 0 && row >= int'(lp) - PE && row <= int'(lp) + PE) c = C_GREEN;
      else if (col == FW - 1 && row >= int'(rp) - PE && row <= int'(rp) + PE) c = C_MAG;
`ifdef PONG_CENTER_NET_EN
      else if (col == FW / 2 && (row % 8) < 4) c = C_GRAY;
`endif
    end
    return {hs, vs, vis, ft, c};
  endfunction

  logic [9:0] sb_q[$];

  // Scoreboard producer: predicts the output each edge will register.
  initial begin
    int n, h, v;
    logic [7:0] sbx, sby, slp, srp;
    n = 0; sbx = 0; sby = 0; slp = 0; srp = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0; sbx = 0; sby = 0; slp = 0; srp = 0;
        sb_q.push_back(10'b1100_000000);
      end else begin
        h = n % HT;
        v = n / HT;
        sb_q.push_back(model_out(h, v, sbx, sby, slp, srp));
        if (h == 0 && v == VA) begin
          sbx = ball_x; sby = ball_y; slp = left_paddle_y; srp = right_paddle_y;
        end
        n = (n + 1) % FRAME;
      end
    end
  end

  // Scoreboard consumer: compares every registered output sample.
  initial begin
    logic [9:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v = {hsync, vsync, visible, frame_tick, red, green, blue};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got %b expected %b", $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic wait_tick(output bit got);
    got = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_tick_timeout: got no tick expected one within %0d cycles", FRAME + 10);
    end
  endtask

  function automatic stat_t stat_upd(input stat_t s, input int h, input int v);
    stat_t r;
    r = s;
    r.cnt++;
    if (h < r.xmin) r.xmin = h;
    if (h > r.xmax) r.xmax = h;
    if (v < r.ymin) r.ymin = v;
    if (v > r.ymax) r.ymax = v;
    return r;
  endfunction

  // Collects pixel statistics for the frame following the next snapshot;
  // optionally changes ball_x at the start of line chg_line of that frame.
  task automatic scan_frame(input int chg_line, input logic [7:0] chg_bx,
                            output stat_t sw, output stat_t sg,
                            output stat_t sm, output stat_t sn);
    int p, h, v;
    bit got;
    stat_t z;
    z = '{cnt: 0, xmin: 9999, xmax: -1, ymin: 9999, ymax: -1};
    sw = z; sg = z; sm = z; sn = z;
    wait_tick(got);
    if (!got) return;
    p = VA * HT;
    repeat (FRAME - 1) begin
      @(negedge clk);
      p = (p + 1) % FRAME;
      h = p % HT;
      v = p / HT;
      if (h == 0 && v == chg_line) ball_x = chg_bx;
      if (visible === 1'b1) begin
        case ({red, green, blue})
          C_WHITE: sw = stat_upd(sw, h, v);
          C_GREEN: sg = stat_upd(sg, h, v);
          C_MAG:   sm = stat_upd(sm, h, v);
          C_GRAY:  sn = stat_upd(sn, h, v);
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset();
    int fall_s, fall_f;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hsync, vsync, visible, frame_tick, red, green, blue} !== 10'b1100_000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {hsync, vsync, visible, frame_tick, red, green, blue}, 10'b1100_000000);
    end
    n_checks++;
    if ({hsync_f, vsync_f, visible_f, frame_tick_f, red_f, green_f, blue_f} !== 10'b1100_000000) begin
      n_fail++;
      $display("FAIL reset_outputs_full: got %b expected %b",
               {hsync_f, vsync_f, visible_f, frame_tick_f, red_f, green_f, blue_f}, 10'b1100_000000);
    end
    reset = 1'b0;
    fall_s = 0;
    fall_f = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk);
      #1;
      if (fall_s == 0 && hsync === 1'b0) fall_s = k;
      if (fall_f == 0 && hsync_f === 1'b0) fall_f = k;
    end
    n_checks++;
    if (fall_f != 657) begin
      n_fail++;
      $display("FAIL hsync_fall_full: got %0d expected 657", fall_f);
    end
    n_checks++;
    if (fall_s != HA + HF + 1) begin
      n_fail++;
      $display("FAIL hsync_fall_small: got %0d expected %0d", fall_s, HA + HF + 1);
    end
  endtask

  task automatic test_sync_widths();
    int vlow, hlow;
    vlow = 0;
    hlow = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (vsync === 1'b0) vlow++;
      if (hsync === 1'b0) hlow++;
    end
    n_checks++;
    if (vlow != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_low_cycles: got %0d expected %0d", vlow, VS * HT);
    end
    n_checks++;
    if (hlow != HS * VT) begin
      n_fail++;
      $display("FAIL hsync_low_cycles: got %0d expected %0d", hlow, HS * VT);
    end
  endtask

  task automatic test_frame_tick();
    bit got;
    int k;
    wait_tick(got);
    k = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      k++;
      if (i == 0) begin
        n_checks++;
        if (frame_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL tick_width: got %b expected 0 one cycle after pulse", frame_tick);
        end
      end
      if (frame_tick === 1'b1) break;
    end
    n_checks++;
    if (k != FRAME) begin
      n_fail++;
      $display("FAIL tick_period: got %0d expected %0d", k, FRAME);
    end
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      k++;
      if (frame_tick === 1'b1) break;
    end
    n_checks++;
    if (k != VA * HT + 1) begin
      n_fail++;
      $display("FAIL tick_after_reset: got %0d expected %0d", k, VA * HT + 1);
    end
  endtask

  stat_t st_w, st_g, st_m, st_n;

  task automatic test_ball();
    ball_x = 8'd10;
    ball_y = 8'd5;
    left_paddle_y = 8'd1;
    right_paddle_y = 8'd6;
    scan_frame(10, 8'd12, st_w, st_g, st_m, st_n);
    n_checks++;
    if ({st_w.cnt, st_w.xmin, st_w.xmax, st_w.ymin, st_w.ymax} !== {32'd16, 32'd40, 32'd43, 32'd20, 32'd23}) begin
      n_fail++;
      $display("FAIL ball_pixels: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=16 x=40..43 y=20..23",
               st_w.cnt, st_w.xmin, st_w.xmax, st_w.ymin, st_w.ymax);
    end
  endtask

  task automatic test_snapshot_and_paddles();
    scan_frame(-1, 8'd0, st_w, st_g, st_m, st_n);
    n_checks++;
    if ({st_w.cnt, st_w.xmin, st_w.xmax, st_w.ymin, st_w.ymax} !== {32'd16, 32'd48, 32'd51, 32'd20, 32'd23}) begin
      n_fail++;
      $display("FAIL snapshot_next_frame: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=16 x=48..51 y=20..23",
               st_w.cnt, st_w.xmin, st_w.xmax, st_w.ymin, st_w.ymax);
    end
    n_checks++;
    if ({st_g.cnt, st_g.xmin, st_g.xmax, st_g.ymin, st_g.ymax} !== {32'd80, 32'd0, 32'd3, 32'd0, 32'd19}) begin
      n_fail++;
      $display("FAIL left_paddle_clip: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=80 x=0..3 y=0..19",
               st_g.cnt, st_g.xmin, st_g.xmax, st_g.ymin, st_g.ymax);
    end
    n_checks++;
    if ({st_m.cnt, st_m.xmin, st_m.xmax, st_m.ymin, st_m.ymax} !== {32'd112, 32'd60, 32'd63, 32'd12, 32'd39}) begin
      n_fail++;
      $display("FAIL right_paddle: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=112 x=60..63 y=12..39",
               st_m.cnt, st_m.xmin, st_m.xmax, st_m.ymin, st_m.ymax);
    end
`ifdef PONG_CENTER_NET_EN
    n_checks++;
    if ({st_n.cnt, st_n.xmin, st_n.xmax, st_n.ymin, st_n.ymax} !== {32'd128, 32'd32, 32'd35, 32'd0, 32'd47}) begin
      n_fail++;
      $display("FAIL center_net: got cnt=%0d x=%0d..%0d y=%0d..%0d expected cnt=128 x=32..35 y=0..47",
               st_n.cnt, st_n.xmin, st_n.xmax, st_n.ymin, st_n.ymax);
    end
`else
    n_checks++;
    if (st_n.cnt !== 0) begin
      n_fail++;
      $display("FAIL center_net_absent: got %0d gray pixels expected 0", st_n.cnt);
    end
`endif
  endtask

  task automatic test_priority_and_range();
    ball_x = 8'd0;
    ball_y = 8'd2;
    scan_frame(-1, 8'd0, st_w, st_g, st_m, st_n);
    n_checks++;
    if ({st_w.cnt, st_w.xmin, st_w.ymin, st_w.ymax, st_g.cnt} !== {32'd16, 32'd0, 32'd8, 32'd11, 32'd64}) begin
      n_fail++;
      $display("FAIL ball_over_paddle: got white=%0d x=%0d y=%0d..%0d green=%0d expected white=16 x=0 y=8..11 green=64",
               st_w.cnt, st_w.xmin, st_w.ymin, st_w.ymax, st_g.cnt);
    end
    ball_x = 8'(FW);
    ball_y = 8'(FH);
    scan_frame(-1, 8'd0, st_w, st_g, st_m, st_n);
    n_checks++;
    if (st_w.cnt !== 0) begin
      n_fail++;
      $display("FAIL ball_out_of_field: got %0d white pixels expected 0", st_w.cnt);
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sync_widths();
    test_frame_tick();
    test_ball();
    test_snapshot_and_paddles();
    test_priority_and_range();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
